// File: rtl/versatile_fifo_sync_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : versatile_fifo_sync_ctrl_if
// Brief    : Request, threshold, address and status bundle of the sync FIFO controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface versatile_fifo_sync_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH:0]   afull_lvl;
  logic [ADDR_WIDTH:0]   aempty_lvl;
  logic [ADDR_WIDTH-1:0] wadr;
  logic [ADDR_WIDTH-1:0] radr;
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH:0]   fill;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, rd_en, afull_lvl, aempty_lvl,
    input  wadr, radr, we, re, fill, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, afull_lvl, aempty_lvl,
    output wadr, radr, we, re, fill, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/versatile_fifo_sync_ctrl.sv
//------------------------------------------------------------------------------
// Module   : versatile_fifo_sync_ctrl
// Brief    : Single-clock FIFO controller: RAM addresses/strobes, fill count, flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module versatile_fifo_sync_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter bit AF_RESET   = 1'b0,
  parameter bit AE_RESET   = 1'b1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              clr,
  versatile_fifo_sync_ctrl_if.slave fifo
);

  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_zero  = '0;

  logic [ADDR_WIDTH:0] r_wptr;
  logic [ADDR_WIDTH:0] r_rptr;
  logic [ADDR_WIDTH:0] r_fill;
  logic                r_full;
  logic                r_empty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_ovf;
  logic                r_unf;

  logic                w_we;
  logic                w_re;
  logic [ADDR_WIDTH:0] w_fill_next;

  // A full FIFO still takes a write when the same cycle frees a slot.
  always_comb begin
    w_re        = fifo.rd_en & ~r_empty;
    w_we        = fifo.wr_en & (~r_full | w_re);
    w_fill_next = r_fill + {c_zero[ADDR_WIDTH:1], w_we} - {c_zero[ADDR_WIDTH:1], w_re};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= AF_RESET;
      r_aempty <= AE_RESET;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (clr) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= AF_RESET;
      r_aempty <= AE_RESET;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wptr   <= r_wptr + {c_zero[ADDR_WIDTH:1], w_we};
      r_rptr   <= r_rptr + {c_zero[ADDR_WIDTH:1], w_re};
      r_fill   <= w_fill_next;
      r_full   <= (w_fill_next == c_depth);
      r_empty  <= (w_fill_next == c_zero);
      // Out-of-range thresholds saturate naturally since fill never exceeds depth.
      r_afull  <= (w_fill_next >= fifo.afull_lvl);
      r_aempty <= (w_fill_next <= fifo.aempty_lvl);
      r_ovf    <= r_ovf | (fifo.wr_en & ~w_we);
      r_unf    <= r_unf | (fifo.rd_en & r_empty);
    end
  end

  assign fifo.wadr         = r_wptr[ADDR_WIDTH-1:0];
  assign fifo.radr         = r_rptr[ADDR_WIDTH-1:0];
  assign fifo.we           = w_we;
  assign fifo.re           = w_re;
  assign fifo.fill         = r_fill;
  assign fifo.fifo_full    = r_full;
  assign fifo.fifo_empty   = r_empty;
  assign fifo.almost_full  = r_afull;
  assign fifo.almost_empty = r_aempty;
  assign fifo.overflow     = r_ovf;
  assign fifo.underflow    = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_versatile_fifo_sync_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_versatile_fifo_sync_ctrl
// Brief    : Directed and random bench with a RAM model and data-order scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_versatile_fifo_sync_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam bit AF_R  = 1'b0;
  localparam bit AE_R  = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  versatile_fifo_sync_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  versatile_fifo_sync_ctrl #(
    .ADDR_WIDTH (AW),
    .AF_RESET   (AF_R),
    .AE_RESET   (AE_R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .fifo  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced once per cycle at the falling edge
  logic [AW:0]  m_fill, m_wptr, m_rptr;
  logic         m_af, m_ae, m_ovf, m_unf;
  logic         e_we, e_re;
  logic [AW:0]  m_next;
  logic [31:0]  mem [DEPTH];
  logic [31:0]  sb_q [$];
  logic [31:0]  wdata;
  logic [31:0]  exp_d;

  task automatic model_reset();
    m_fill = '0; m_wptr = '0; m_rptr = '0;
    m_af = AF_R; m_ae = AE_R; m_ovf = 1'b0; m_unf = 1'b0;
    sb_q.delete();
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_fill",  32'(bus.fill), 0);
      chk("rst_empty", 32'(bus.fifo_empty), 1);
      chk("rst_full",  32'(bus.fifo_full), 0);
      chk("rst_af",    32'(bus.almost_full), 32'(AF_R));
      chk("rst_ae",    32'(bus.almost_empty), 32'(AE_R));
      chk("rst_ovf",   32'(bus.overflow), 0);
      chk("rst_unf",   32'(bus.underflow), 0);
      chk("rst_wadr",  32'(bus.wadr), 0);
      chk("rst_radr",  32'(bus.radr), 0);
      model_reset();
    end else begin
      chk("fill",   32'(bus.fill), 32'(m_fill));
      chk("full",   32'(bus.fifo_full), 32'(m_fill == DEPTH));
      chk("empty",  32'(bus.fifo_empty), 32'(m_fill == 0));
      chk("afull",  32'(bus.almost_full), 32'(m_af));
      chk("aempty", 32'(bus.almost_empty), 32'(m_ae));
      chk("ovf",    32'(bus.overflow), 32'(m_ovf));
      chk("unf",    32'(bus.underflow), 32'(m_unf));
      chk("wadr",   32'(bus.wadr), 32'(m_wptr[AW-1:0]));
      chk("radr",   32'(bus.radr), 32'(m_rptr[AW-1:0]));
      chk("invariant", 32'(4'(bus.wadr - bus.radr)), 32'(bus.fill[AW-1:0]));
      e_re = bus.rd_en & (m_fill != 0);
      e_we = bus.wr_en & ((m_fill != DEPTH) | e_re);
      chk("we", 32'(bus.we), 32'(e_we));
      chk("re", 32'(bus.re), 32'(e_re));
      // RAM is read before it is written, matching a read-first dual-port RAM
      if (bus.re) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_data: pop with empty scoreboard, radr=%0d", bus.radr);
        end else begin
          exp_d = sb_q.pop_front();
          chk("rd_data", mem[bus.radr], exp_d);
        end
      end
      if (bus.we) mem[bus.wadr] = wdata;
      if (clr) begin
        model_reset();
      end else begin
        if (e_we) sb_q.push_back(wdata);
        m_next = m_fill + (AW+1)'(e_we) - (AW+1)'(e_re);
        m_ovf  = m_ovf | (bus.wr_en & ~e_we);
        m_unf  = m_unf | (bus.rd_en & (m_fill == 0));
        m_af   = ({27'd0, m_next} >= 32'(bus.afull_lvl));
        m_ae   = ({27'd0, m_next} <= 32'(bus.aempty_lvl));
        m_wptr = m_wptr + (AW+1)'(e_we);
        m_rptr = m_rptr + (AW+1)'(e_re);
        m_fill = m_next;
      end
    end
  end

  task automatic drive(input logic w, input logic r);
    bus.wr_en = w;
    bus.rd_en = r;
    wdata     = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.afull_lvl  = 5'd12;
    bus.aempty_lvl = 5'd3;
    wdata          = '0;
    repeat (2) tick();
    chk("init_fill", 32'(bus.fill), 0);
    chk("init_ae",   32'(bus.almost_empty), 1);
    rst_n = 1'b1;

    // Fill from empty: addresses 0..15, full one cycle after the 16th write
    for (int i = 0; i < 16; i++) begin
      drive(1, 0);
      #1;
      chk("t1_we", 32'(bus.we), 1);
      chk("t1_wadr", 32'(bus.wadr), 32'(i));
      tick();
      chk("t1_fill", 32'(bus.fill), 32'(i + 1));
      chk("t1_empty", 32'(bus.fifo_empty), 0);
      chk("t1_full", 32'(bus.fifo_full), 32'(i == 15));
    end

    // Rejected write when full, then clear
    drive(1, 0);
    #1;
    chk("t2_we", 32'(bus.we), 0);
    tick();
    chk("t2_ovf", 32'(bus.overflow), 1);
    chk("t2_fill", 32'(bus.fill), 16);
    drive(0, 0);
    tick();
    chk("t2_ovf_sticky", 32'(bus.overflow), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t2_clr_fill", 32'(bus.fill), 0);
    chk("t2_clr_ovf", 32'(bus.overflow), 0);
    chk("t2_clr_empty", 32'(bus.fifo_empty), 1);

    // Simultaneous read/write while full: pointers wrap twice
    for (int i = 0; i < 16; i++) begin
      drive(1, 0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1, 1);
      #1;
      chk("t3_we", 32'(bus.we), 1);
      chk("t3_re", 32'(bus.re), 1);
      chk("t3_wadr", 32'(bus.wadr), 32'(i % 16));
      chk("t3_radr", 32'(bus.radr), 32'(i % 16));
      tick();
      chk("t3_fill", 32'(bus.fill), 16);
      chk("t3_full", 32'(bus.fifo_full), 1);
    end
    chk("t3_ovf", 32'(bus.overflow), 0);

    // Read and write while empty: read rejected, write accepted
    clr = 1'b1;
    drive(0, 0);
    tick();
    clr = 1'b0;
    drive(1, 1);
    #1;
    chk("t4_re", 32'(bus.re), 0);
    chk("t4_we", 32'(bus.we), 1);
    tick();
    chk("t4_unf", 32'(bus.underflow), 1);
    chk("t4_fill", 32'(bus.fill), 1);

    // Almost-full / almost-empty thresholds
    clr = 1'b1;
    drive(0, 0);
    tick();
    clr = 1'b0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      drive(1, 0);
      tick();
      chk("t5_ae", 32'(bus.almost_empty), 32'(k <= 3));
      chk("t5_af", 32'(bus.almost_full), 32'(k >= 12));
    end
    drive(0, 0);
    bus.afull_lvl = 5'd17;
    #1;
    chk("t5_af_before", 32'(bus.almost_full), 1);
    tick();
    chk("t5_af_17", 32'(bus.almost_full), 0);
    bus.afull_lvl  = 5'd0;
    bus.aempty_lvl = 5'd16;
    tick();
    chk("t5_af_0", 32'(bus.almost_full), 1);
    chk("t5_ae_16", 32'(bus.almost_empty), 1);
    bus.afull_lvl  = 5'd12;
    bus.aempty_lvl = 5'd3;

    // Asynchronous reset mid-burst, then first write lands at address 0
    drive(1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_fill", 32'(bus.fill), 0);
    chk("t6_async_empty", 32'(bus.fifo_empty), 1);
    chk("t6_async_wadr", 32'(bus.wadr), 0);
    tick();
    #2;
    rst_n = 1'b1;
    drive(1, 0);
    #1;
    chk("t6_first_wadr", 32'(bus.wadr), 0);
    chk("t6_first_we", 32'(bus.we), 1);
    tick();

    // Random traffic with occasional clear, threshold change and async reset
    for (int i = 0; i < 10000; i++) begin
      int wp;
      wp = ((i / 500) % 2 == 0) ? 70 : 35;
      drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp));
      clr = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 199) == 0) begin
        bus.afull_lvl  = 5'($urandom_range(0, 17));
        bus.aempty_lvl = 5'($urandom_range(0, 17));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rnd_async_fill", 32'(bus.fill), 0);
        chk("rnd_async_wadr", 32'(bus.wadr), 0);
        tick();
        #2;
        rst_n = 1'b1;
      end
      tick();
    end
    clr = 1'b0;
    drive(0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/versatile_fifo_sync_ctrl.md
Name: versatile_fifo_sync_ctrl

Overview:
Single-clock FIFO controller for the versatile FIFO family. It generates RAM write/read addresses and enables, and keeps an exact fill count. It produces registered full/empty flags, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits beside a 2^ADDR_WIDTH-entry dual-port RAM in same-clock bridges, where the async comparator's synchroniser latency is not needed.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2^ADDR_WIDTH entries
AF_RESET, 0, almost_full value driven during reset
AE_RESET, 1, almost_empty value driven during reset

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; same effect as reset, one cycle
wr_en  input  1  write request
rd_en  input  1  read request
afull_lvl  input  ADDR_WIDTH+1  almost-full threshold (entries)
aempty_lvl  input  ADDR_WIDTH+1  almost-empty threshold (entries)
wadr  output  ADDR_WIDTH  RAM write address (current write pointer)
radr  output  ADDR_WIDTH  RAM read address (current read pointer)
we  output  1  qualified RAM write strobe (combinational)
re  output  1  qualified read/pop strobe (combinational)
fill  output  ADDR_WIDTH+1  entries held, 0..DEPTH
fifo_full  output  1  fill == DEPTH
fifo_empty  output  1  fill == 0
almost_full  output  1  fill >= afull_lvl
almost_empty  output  1  fill <= aempty_lvl
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, async) and clr (sync, priority over all other inputs):
  - wptr = 0, rptr = 0, fill = 0
  - fifo_empty = 1, fifo_full = 0
  - almost_full = AF_RESET, almost_empty = AE_RESET
  - overflow = 0, underflow = 0
- Internal pointers are ADDR_WIDTH+1 bits. The MSB is a wrap bit. wadr and radr are the low ADDR_WIDTH bits. Pointers wrap from 2^(ADDR_WIDTH+1)-1 to 0 by natural overflow.
- Acceptance:
  - re = rd_en & !fifo_empty
  - we = wr_en & (!fifo_full | re); a write is accepted when full only if a read is accepted in the same cycle.
  - Write while empty is accepted; a simultaneous read while empty is rejected (no pass-through).
- Update on each clk edge:
  - wptr += we; rptr += re
  - fill_next = fill + we - re, computed in ADDR_WIDTH+1 bits; never exceeds DEPTH or goes below 0.
  - we & re together: fill unchanged, both pointers advance.
- Flags are registered from fill_next, so they update on the same edge as fill (one-cycle latency from the accepted op). No combinational path from wr_en/rd_en to any flag.
  - fifo_full = (fill_next == DEPTH)
  - fifo_empty = (fill_next == 0)
  - almost_full = (fill_next >= afull_lvl); almost_empty = (fill_next <= aempty_lvl)
  - Thresholds are sampled every cycle, so a threshold change takes effect one cycle later even with no traffic.
  - afull_lvl = 0 forces almost_full = 1. afull_lvl > DEPTH forces it to 0. aempty_lvl >= DEPTH forces almost_empty = 1.
- Error flags:
  - overflow sets on wr_en & !we; underflow sets on rd_en & fifo_empty.
  - Both stay set until reset or clr; no other input clears them.
  - A rejected request changes no pointer and no fill.
- Invariant: fill == wptr - rptr (mod 2^(ADDR_WIDTH+1)) at all times; the bench checks it as an assertion.
- Reset asserted mid-burst: all state returns to the reset values immediately, with no wait for clk. The first accepted write after rst_n deasserts lands at wadr = 0.

Test Plan:
1. ADDR_WIDTH=4, reset, then 16 writes -> wadr 0..15, fill counts 1..16. fifo_full = 1 the cycle after the 16th write; fifo_empty = 0 the cycle after the 1st.
2. Full FIFO, wr_en=1 rd_en=0 one cycle -> we = 0, overflow = 1 and stays 1, fill stays 16. Then clr -> fill = 0, overflow = 0, fifo_empty = 1.
3. Full FIFO, wr_en = rd_en = 1 for 40 cycles -> we = re = 1 every cycle, fill stays 16, fifo_full stays 1, wadr/radr wrap past 15 twice, no overflow.
4. Empty FIFO, wr_en = rd_en = 1 -> re = 0, underflow = 1, write accepted, fill = 1 next cycle.
5. afull_lvl = 12, aempty_lvl = 3, fill 0 to 16 by single writes -> almost_empty drops on the edge where fill becomes 4, almost_full rises on the edge where fill becomes 12. Change afull_lvl to 17 -> almost_full = 0 one cycle later.
6. Random we/re with rst_n pulsed asynchronously mid-stream for 10k cycles -> scoreboard data order matches, fill == wptr - rptr always, flags match fill, outputs at reset values while rst_n is low.
